// File: rtl/microwave_pkg.sv
// microwave_timer shared types, defaults and duty helper.
// Optional add-time feature: MICROWAVE_ADD_TIME_EN.
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        COOK,
        PAUSE,
        BELL
    } state_t;

    localparam int TIME_W_DEF     = 8;
    localparam int TICK_DIV_DEF   = 16;
    localparam int PWR_LEVELS_DEF = 4;
    localparam int BELL_TICKS_DEF = 3;
    localparam int ADD_TICKS_DEF  = 30;

    // heater stays on while tick_cnt is below this
    function automatic int duty_thr(input int p, input int div, input int lv);
        return ((p + 1) * div) / lv;
    endfunction

endpackage

// File: rtl/microwave_timer_if.sv
// Front-panel inputs and driver outputs of the microwave timer.
// master = panel side, slave = timer.
interface microwave_timer_if #(
    parameter int TIME_W = microwave_pkg::TIME_W_DEF,
    parameter int PWR_W  = 2
);
    logic              door;
    logic              start;
    logic              cancel;
    logic [TIME_W-1:0] time_in;
    logic [PWR_W-1:0]  power;
    logic              heat;
    logic              light;
    logic              bell;
    logic              busy;
    logic [TIME_W-1:0] remaining;

    modport master (
        output door, start, cancel, time_in, power,
        input  heat, light, bell, busy, remaining
    );

    modport slave (
        input  door, start, cancel, time_in, power,
        output heat, light, bell, busy, remaining
    );
endinterface

// File: rtl/tick_divider.sv
// Tick prescaler: counts 0..DIV-1 while enabled, pulses tick on wrap.
// Clear wins over enable; disabled means hold.
module tick_divider #(
    parameter int DIV = 16,
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tick
);
    logic wrap;

    assign wrap = (cnt == CW'(DIV - 1));
    assign tick = en && wrap;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/microwave_timer.sv
// Microwave cook timer: countdown, duty-cycled heater, timed bell.
// Define MICROWAVE_ADD_TIME_EN to let start edges add time while cooking.
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int TIME_W     = TIME_W_DEF,
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int PWR_LEVELS = PWR_LEVELS_DEF,
    parameter int BELL_TICKS = BELL_TICKS_DEF,
    parameter int ADD_TICKS  = ADD_TICKS_DEF
) (
    input logic              clk,
    input logic              nrst,
    microwave_timer_if.slave bus
);
    localparam int PW = $clog2(PWR_LEVELS);
    localparam int CW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BELL_TICKS + 1);
    localparam logic [TIME_W:0] MAXV = {1'b0, {TIME_W{1'b1}}};

    state_t            state, state_n;
    logic [TIME_W-1:0] rem, rem_n, rem_add;
    logic [TIME_W:0]   sum;
    logic [PW-1:0]     pwr_q, pwr_n, pwr_in;
    logic [BW-1:0]     bell_cnt, bell_n;
    logic [CW-1:0]     tick_cnt;
    logic              tick, div_en, div_clr, add;

    tick_divider #(.DIV(TICK_DIV)) u_div (
        .clk  (clk),
        .nrst (nrst),
        .en   (div_en),
        .clr  (div_clr),
        .cnt  (tick_cnt),
        .tick (tick)
    );

    assign pwr_in = (int'(bus.power) >= PWR_LEVELS)
                  ? PW'(PWR_LEVELS - 1) : bus.power;

    assign sum     = {1'b0, rem} + (TIME_W + 1)'(ADD_TICKS);
    assign rem_add = (sum > MAXV) ? MAXV[TIME_W-1:0] : sum[TIME_W-1:0];

`ifdef MICROWAVE_ADD_TIME_EN
    logic start_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) start_q <= 1'b0;
        else       start_q <= bus.start;
    end

    assign add = bus.start && !start_q;
`else
    assign add = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            rem      <= '0;
            pwr_q    <= '0;
            bell_cnt <= '0;
        end else begin
            state    <= state_n;
            rem      <= rem_n;
            pwr_q    <= pwr_n;
            bell_cnt <= bell_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        pwr_n   = pwr_q;
        bell_n  = bell_cnt;
        div_en  = 1'b0;
        div_clr = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.door) begin
                    state_n = OPEN;
                end else if (bus.start && bus.time_in != '0) begin
                    state_n = COOK;
                    rem_n   = bus.time_in;
                    pwr_n   = pwr_in;
                    div_clr = 1'b1;
                end
            end
            OPEN: begin
                if (!bus.door) state_n = IDLE;
            end
            COOK: begin
                if (bus.door) begin
                    state_n = PAUSE;
                end else if (bus.cancel) begin
                    state_n = IDLE;
                    rem_n   = '0;
                end else begin
                    div_en = 1'b1;
                    // an add-time press outranks the tick it coincides with
                    if (add) begin
                        rem_n = rem_add;
                    end else if (tick) begin
                        if (rem > TIME_W'(1)) begin
                            rem_n = rem - TIME_W'(1);
                        end else begin
                            rem_n   = '0;
                            bell_n  = '0;
                            state_n = BELL;
                            div_clr = 1'b1;
                        end
                    end
                end
            end
            PAUSE: begin
                if (bus.door && bus.cancel) begin
                    state_n = OPEN;
                    rem_n   = '0;
                end else if (!bus.door) begin
                    state_n = COOK;
                end
            end
            BELL: begin
                if (bus.door) begin
                    state_n = OPEN;
                end else if (bus.cancel) begin
                    state_n = IDLE;
                end else begin
                    div_en = 1'b1;
                    if (tick) begin
                        if (bell_cnt == BW'(BELL_TICKS - 1)) state_n = IDLE;
                        else bell_n = bell_cnt + BW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.light     = (state == OPEN) || (state == COOK) || (state == PAUSE);
    assign bus.busy      = (state == COOK) || (state == PAUSE);
    assign bus.bell      = (state == BELL);
    assign bus.remaining = rem;
    assign bus.heat      = (state == COOK) &&
        (int'(tick_cnt) < duty_thr(int'(pwr_q), TICK_DIV, PWR_LEVELS));
endmodule

// File: tb/tb_microwave_timer.sv
// Scoreboard bench for microwave_timer with a short tick (TICK_DIV=4).
// Expected output words are queued per cycle and popped after each edge.
module tb_microwave_timer;
    localparam int TW = 8;
    localparam int TD = 4;
    localparam int PL = 4;
    localparam int BT = 2;
    localparam int AT = 30;

    logic clk = 1'b0;
    logic nrst;
    int   errs = 0;
    int   checks = 0;
    logic [11:0] sb_q[$];

    always #5 clk = ~clk;

    microwave_timer_if #(.TIME_W(TW), .PWR_W($clog2(PL))) mw ();

    microwave_timer #(
        .TIME_W(TW), .TICK_DIV(TD), .PWR_LEVELS(PL),
        .BELL_TICKS(BT), .ADD_TICKS(AT)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (mw)
    );

    wire [11:0] obs = {mw.heat, mw.light, mw.bell, mw.busy, mw.remaining};

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h (heat,light,bell,busy|rem)", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pk(input bit h, input bit l, input bit b,
                                       input bit bz, input int rem);
        return {h, l, b, bz, 8'(rem)};
    endfunction

    task automatic step(input string tag, input logic [11:0] e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        chk(tag, obs, sb_q.pop_front());
    endtask

    // COOK cycles n0..n1-1 counted from the cycle COOK was first entered
    task automatic cook(input string tag, input int t, input int p,
                        input int n0, input int n1);
        int thr;
        thr = ((p + 1) * TD) / PL;
        for (int n = n0; n < n1; n++)
            step(tag, pk((n % TD) < thr, 1'b1, 1'b0, 1'b1, t - n / TD));
    endtask

    task automatic bell_run(input string tag);
        for (int j = 0; j < BT * TD; j++)
            step(tag, pk(1'b0, 1'b0, 1'b1, 1'b0, 0));
    endtask

    task automatic launch(input string tag, input int t, input int p);
        mw.time_in = 8'(t);
        mw.power   = 2'(p);
        mw.start   = 1'b1;
        cook(tag, t, p, 0, 1);
        mw.start   = 1'b0;
    endtask

    task automatic full_run(input string tag, input int t, input int p);
        launch(tag, t, p);
        cook(tag, t, p, 1, t * TD);
        bell_run({tag, "_bell"});
        step({tag, "_end"}, 12'h000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_add;
        nrst = 1'b0;
        mw.door = 1'b0; mw.start = 1'b0; mw.cancel = 1'b0;
        mw.time_in = '0; mw.power = '0;
        #1;
        chk("reset", obs, 12'h000);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        step("idle", 12'h000);

        full_run("p3_t3", 3, 3);
        full_run("p0_t3", 3, 0);
        full_run("p1_t2", 2, 1);

        // pause after six counted cycles, hold ten, resume for fourteen
        launch("pause", 5, 3);
        cook("pause", 5, 3, 1, 7);
        mw.door = 1'b1;
        repeat (10) step("pause_hold", pk(1'b0, 1'b1, 1'b0, 1'b1, 4));
        mw.door = 1'b0;
        cook("resume", 5, 3, 6, 20);
        bell_run("resume_bell");
        step("resume_end", 12'h000);

        launch("cancel", 5, 3);
        cook("cancel", 5, 3, 1, 5);
        mw.cancel = 1'b1;
        step("cancel_cook", 12'h000);
        mw.cancel = 1'b0;
        step("cancel_idle", 12'h000);

        launch("pcan", 5, 3);
        mw.door = 1'b1;
        step("pcan_pause", pk(1'b0, 1'b1, 1'b0, 1'b1, 5));
        mw.cancel = 1'b1;
        step("pcan_open", pk(1'b0, 1'b1, 1'b0, 1'b0, 0));
        mw.cancel = 1'b0;
        mw.door = 1'b0;
        step("pcan_idle", 12'h000);

        mw.time_in = '0;
        mw.start = 1'b1;
        step("t0_start", 12'h000);
        step("t0_start2", 12'h000);
        mw.door = 1'b1;
        step("door_start", pk(1'b0, 1'b1, 1'b0, 1'b0, 0));
        mw.cancel = 1'b1;
        step("open_cancel", pk(1'b0, 1'b1, 1'b0, 1'b0, 0));
        mw.cancel = 1'b0;
        mw.door = 1'b0;
        step("open_close", 12'h000);
        mw.start = 1'b0;

        launch("bdoor", 1, 3);
        cook("bdoor", 1, 3, 1, 4);
        step("bdoor_b0", pk(1'b0, 1'b0, 1'b1, 1'b0, 0));
        mw.door = 1'b1;
        step("bdoor_open", pk(1'b0, 1'b1, 1'b0, 1'b0, 0));
        mw.door = 1'b0;
        step("bdoor_idle", 12'h000);

        launch("bcan", 1, 3);
        cook("bcan", 1, 3, 1, 4);
        step("bcan_b0", pk(1'b0, 1'b0, 1'b1, 1'b0, 0));
        mw.cancel = 1'b1;
        step("bcan_idle", 12'h000);
        mw.cancel = 1'b0;

`ifdef MICROWAVE_ADD_TIME_EN
        exp_add = 255;
`else
        exp_add = 240;
`endif
        launch("add", 240, 2);
        cook("add", 240, 2, 1, 2);
        mw.start = 1'b1;
        step("add_edge", pk(1'b1, 1'b1, 1'b0, 1'b1, exp_add));
        step("add_held", pk(1'b0, 1'b1, 1'b0, 1'b1, exp_add));
        mw.start = 1'b0;
        mw.cancel = 1'b1;
        step("add_cancel", 12'h000);
        mw.cancel = 1'b0;

        launch("arst", 3, 3);
        cook("arst", 3, 3, 1, 3);
        nrst = 1'b0;
        #1;
        sb_q.push_back(12'h000);
        chk("arst_async", obs, sb_q.pop_front());
        #2;
        nrst = 1'b1;
        step("arst_idle", 12'h000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
